// File: rtl/coord_frame_tx.sv
// Coordinate frame UART transmitter: sends HDR0 HDR1, x/y/z big-endian and an additive
// checksum as 15 contiguous 8N1 bytes, each bit held CLK_FREQ/BAUD clock cycles.
module coord_frame_tx #(
   parameter int unsigned CLK_FREQ = 50_000_000,
   parameter int unsigned BAUD     = 115200,
   parameter logic [7:0]  HDR0     = 8'hAA,
   parameter logic [7:0]  HDR1     = 8'h55
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        start,
   input  logic        abort,
   input  logic [31:0] x,
   input  logic [31:0] y,
   input  logic [31:0] z,
   output logic        busy,
   output logic        done,
   output logic        tx
);

   localparam int unsigned     BAUD_DIV  = CLK_FREQ / BAUD;
   localparam int unsigned     CNT_W     = (BAUD_DIV > 1) ? $clog2(BAUD_DIV) : 1;
   localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(BAUD_DIV - 1);
   localparam logic [3:0]      LAST_BYTE = 4'd14;

   localparam logic [1:0] IDLE      = 2'd0;
   localparam logic [1:0] START_BIT = 2'd1;
   localparam logic [1:0] DATA      = 2'd2;
   localparam logic [1:0] STOP_BIT  = 2'd3;

   logic [1:0]       state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [2:0]       bit_idx_q, bit_idx_d;
   logic [3:0]       byte_idx_q, byte_idx_d;
   logic [7:0]       shift_q, shift_d;
   logic [31:0]      x_q, x_d, y_q, y_d, z_q, z_d;
   logic             tx_q, tx_d;
   logic             done_q, done_d;
   logic [7:0]       chk;
   logic [7:0]       cur_byte;
   logic             bit_end;

   // Checksum covers only the 12 latched coordinate bytes, not the header.
   always_comb begin
      chk = x_q[31:24] + x_q[23:16] + x_q[15:8] + x_q[7:0]
          + y_q[31:24] + y_q[23:16] + y_q[15:8] + y_q[7:0]
          + z_q[31:24] + z_q[23:16] + z_q[15:8] + z_q[7:0];
   end

   always_comb begin
      case (byte_idx_q)
         4'd0:    cur_byte = HDR0;
         4'd1:    cur_byte = HDR1;
         4'd2:    cur_byte = x_q[31:24];
         4'd3:    cur_byte = x_q[23:16];
         4'd4:    cur_byte = x_q[15:8];
         4'd5:    cur_byte = x_q[7:0];
         4'd6:    cur_byte = y_q[31:24];
         4'd7:    cur_byte = y_q[23:16];
         4'd8:    cur_byte = y_q[15:8];
         4'd9:    cur_byte = y_q[7:0];
         4'd10:   cur_byte = z_q[31:24];
         4'd11:   cur_byte = z_q[23:16];
         4'd12:   cur_byte = z_q[15:8];
         4'd13:   cur_byte = z_q[7:0];
         default: cur_byte = chk;
      endcase
   end

   assign bit_end = (cnt_q == CNT_MAX);

   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      bit_idx_d  = bit_idx_q;
      byte_idx_d = byte_idx_q;
      shift_d    = shift_q;
      x_d        = x_q;
      y_d        = y_q;
      z_d        = z_q;
      tx_d       = tx_q;
      done_d     = 1'b0;
      if (state_q == IDLE) begin
         // abort outranks start even when idle: the frame is not launched.
         if (start && !abort) begin
            state_d    = START_BIT;
            cnt_d      = '0;
            bit_idx_d  = '0;
            byte_idx_d = '0;
            x_d        = x;
            y_d        = y;
            z_d        = z;
            tx_d       = 1'b0;
         end
      end else if (abort) begin
         state_d    = IDLE;
         cnt_d      = '0;
         bit_idx_d  = '0;
         byte_idx_d = '0;
         tx_d       = 1'b1;
      end else if (!bit_end) begin
         cnt_d = cnt_q + 1'b1;
      end else begin
         cnt_d = '0;
         case (state_q)
            START_BIT: begin
               state_d   = DATA;
               bit_idx_d = '0;
               tx_d      = cur_byte[0];
               shift_d   = {1'b0, cur_byte[7:1]};
            end
            DATA: begin
               if (bit_idx_q == 3'd7) begin
                  state_d = STOP_BIT;
                  tx_d    = 1'b1;
               end else begin
                  bit_idx_d = bit_idx_q + 3'd1;
                  tx_d      = shift_q[0];
                  shift_d   = shift_q >> 1;
               end
            end
            STOP_BIT: begin
               if (byte_idx_q == LAST_BYTE) begin
                  state_d    = IDLE;
                  byte_idx_d = '0;
                  done_d     = 1'b1;
                  tx_d       = 1'b1;
               end else begin
                  state_d    = START_BIT;
                  byte_idx_d = byte_idx_q + 4'd1;
                  tx_d       = 1'b0;
               end
            end
            default: begin
               state_d = IDLE;
               tx_d    = 1'b1;
            end
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= IDLE;
         cnt_q      <= '0;
         bit_idx_q  <= '0;
         byte_idx_q <= '0;
         shift_q    <= '0;
         x_q        <= '0;
         y_q        <= '0;
         z_q        <= '0;
         tx_q       <= 1'b1;
         done_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         bit_idx_q  <= bit_idx_d;
         byte_idx_q <= byte_idx_d;
         shift_q    <= shift_d;
         x_q        <= x_d;
         y_q        <= y_d;
         z_q        <= z_d;
         tx_q       <= tx_d;
         done_q     <= done_d;
      end
   end

   assign busy = (state_q != IDLE);
   assign done = done_q;
   assign tx   = tx_q;

endmodule

// File: tb/tb_coord_frame_tx.sv
// Randomized self-checking bench for coord_frame_tx; the expected serial line is
// derived cycle by cycle from the frame byte list and 8N1 bit positions.
module tb_coord_frame_tx;

   localparam int unsigned CLK_FREQ = 1_200_000;
   localparam int unsigned BAUD     = 100_000;
   localparam int          DIV      = 12;
   localparam int          NCYC     = 15 * 10 * DIV;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        start = 1'b0;
   logic        abort = 1'b0;
   logic [31:0] x = '0;
   logic [31:0] y = '0;
   logic [31:0] z = '0;
   logic        busy;
   logic        done;
   logic        tx;

   int n_checks = 0;
   int n_fail   = 0;

   coord_frame_tx #(
      .CLK_FREQ (CLK_FREQ),
      .BAUD     (BAUD),
      .HDR0     (8'hAA),
      .HDR1     (8'h55)
   ) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .start (start),
      .abort (abort),
      .x     (x),
      .y     (y),
      .z     (z),
      .busy  (busy),
      .done  (done),
      .tx    (tx)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
      end
   endtask

   // Byte i of the frame for coordinates (xv, yv, zv).
   function automatic logic [7:0] model_byte(input int i, input logic [31:0] xv,
                                             input logic [31:0] yv, input logic [31:0] zv);
      logic [31:0] word;
      int          sum;
      if (i == 0) return 8'hAA;
      if (i == 1) return 8'h55;
      if (i == 14) begin
         sum = 0;
         for (int j = 2; j < 14; j++) sum += int'(model_byte(j, xv, yv, zv));
         return 8'(sum % 256);
      end
      word = ((i - 2) / 4 == 0) ? xv : ((i - 2) / 4 == 1) ? yv : zv;
      word = word >> (8 * (3 - (i - 2) % 4));
      return word[7:0];
   endfunction

   // Expected line level k cycles after the accepting edge.
   function automatic logic model_line(input int k, input logic [31:0] xv,
                                       input logic [31:0] yv, input logic [31:0] zv);
      int          pos;
      logic [7:0]  b;
      pos = k / DIV;
      if (pos % 10 == 0) return 1'b0;
      if (pos % 10 == 9) return 1'b1;
      b = model_byte(pos / 10, xv, yv, zv);
      return b[pos % 10 - 1];
   endfunction

   // Called at a negedge; returns at the negedge of the done cycle (or after the
   // abort/reset recovery). stop_kind: 0 none, 1 abort at cycle stop_at, 2 reset.
   task automatic run_frame(input logic [31:0] xv, input logic [31:0] yv, input logic [31:0] zv,
                            input int stop_at, input int stop_kind, input bit jam,
                            input string name);
      logic [7:0] got [15];
      int wave_err = 0;
      int busy_err = 0;
      int done_err = 0;
      int pos;
      for (int i = 0; i < 15; i++) got[i] = 8'h00;
      start = 1'b1;
      x = xv;
      y = yv;
      z = zv;
      @(negedge clk);
      start = 1'b0;
      if (jam) begin
         x = ~xv;
         y = xv ^ yv;
         z = 32'h1234_5678;
      end
      for (int k = 0; k < NCYC; k++) begin
         if (tx !== model_line(k, xv, yv, zv)) wave_err++;
         if (busy !== 1'b1) busy_err++;
         if (done !== 1'b0) done_err++;
         pos = k / DIV;
         if (k % DIV == DIV / 2 && pos % 10 >= 1 && pos % 10 <= 8) got[pos / 10][pos % 10 - 1] = tx;
         start = jam && (k == 5 * DIV || k == NCYC / 2 || k == NCYC - 1);
         if (k == stop_at) begin
            check({name, "_wave_before_stop"}, wave_err, 0);
            check({name, "_busy_before_stop"}, busy_err, 0);
            if (stop_kind == 1) begin
               abort = 1'b1;
               @(negedge clk);
               abort = 1'b0;
               check({name, "_abort_tx"}, tx, 1);
               check({name, "_abort_busy"}, busy, 0);
               check({name, "_abort_done"}, done, 0);
            end else begin
               #2 rst_n = 1'b0;
               #1;
               check({name, "_rst_tx_async"}, tx, 1);
               check({name, "_rst_busy_async"}, busy, 0);
               check({name, "_rst_done_async"}, done, 0);
               @(negedge clk);
               @(negedge clk);
               rst_n = 1'b1;
            end
            done_err = 0;
            busy_err = 0;
            wave_err = 0;
            for (int m = 0; m < 3 * DIV; m++) begin
               @(negedge clk);
               if (done !== 1'b0) done_err++;
               if (busy !== 1'b0) busy_err++;
               if (tx !== 1'b1) wave_err++;
            end
            check({name, "_idle_no_done"}, done_err, 0);
            check({name, "_idle_busy_low"}, busy_err, 0);
            check({name, "_idle_tx_high"}, wave_err, 0);
            return;
         end
         @(negedge clk);
      end
      start = 1'b0;
      check({name, "_tx_wave"}, wave_err, 0);
      check({name, "_busy_span"}, busy_err, 0);
      check({name, "_no_early_done"}, done_err, 0);
      check({name, "_done_pulse"}, done, 1);
      check({name, "_busy_end"}, busy, 0);
      check({name, "_tx_end"}, tx, 1);
      for (int i = 0; i < 15; i++)
         check($sformatf("%s_byte%0d", name, i), got[i], model_byte(i, xv, yv, zv));
   endtask

   initial begin
      logic [31:0] rx, ry, rz;
      int          stray;
      rst_n = 1'b0;
      repeat (3) @(negedge clk);
      check("reset_tx", tx, 1);
      check("reset_busy", busy, 0);
      check("reset_done", done, 0);
      rst_n = 1'b1;
      repeat (2) @(negedge clk);
      check("idle_tx", tx, 1);

      run_frame(32'h0007_6666, 32'h0012_0000, 32'h0005_3333, -1, 0, 1'b0, "plan");
      @(negedge clk);
      check("plan_done_one_cycle", done, 0);
      check("plan_tx_after", tx, 1);
      repeat (4) @(negedge clk);

      run_frame(32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, -1, 0, 1'b0, "wrap");
      @(negedge clk);

      rx = $urandom; ry = $urandom; rz = $urandom;
      run_frame(rx, ry, rz, -1, 0, 1'b1, "jam");
      stray = 0;
      for (int m = 0; m < 3 * DIV; m++) begin
         @(negedge clk);
         if (busy !== 1'b0 || tx !== 1'b1) stray++;
      end
      check("jam_not_queued", stray, 0);

      rx = $urandom; ry = $urandom; rz = $urandom;
      run_frame(rx, ry, rz, -1, 0, 1'b0, "chain_a");
      rx = $urandom; ry = $urandom; rz = $urandom;
      run_frame(rx, ry, rz, -1, 0, 1'b0, "chain_b");
      @(negedge clk);

      rx = $urandom; ry = $urandom; rz = $urandom;
      run_frame(rx, ry, rz, 300, 1, 1'b0, "abort");
      rx = $urandom; ry = $urandom; rz = $urandom;
      run_frame(rx, ry, rz, -1, 0, 1'b0, "post_abort");
      @(negedge clk);

      start = 1'b1;
      abort = 1'b1;
      @(negedge clk);
      start = 1'b0;
      abort = 1'b0;
      check("abort_beats_start_busy", busy, 0);
      check("abort_beats_start_tx", tx, 1);
      @(negedge clk);

      rx = $urandom; ry = $urandom; rz = $urandom;
      run_frame(rx, ry, rz, 900, 2, 1'b0, "rst");
      rx = $urandom; ry = $urandom; rz = $urandom;
      run_frame(rx, ry, rz, -1, 0, 1'b0, "post_rst");

      for (int r = 0; r < 3; r++) begin
         repeat ($urandom_range(1, 5)) @(negedge clk);
         rx = $urandom; ry = $urandom; rz = $urandom;
         run_frame(rx, ry, rz, -1, 0, 1'b0, $sformatf("rand%0d", r));
      end
      @(negedge clk);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
